// File: rtl/tbird_switch_conditioner_if.sv
// Dashboard switch bundle between the raw inputs and the conditioner.
//   raw_left/raw_right/raw_haz/raw_brk : asynchronous, bouncy switch levels
//   sw   : clean mode code {brake, left, right}
//   chg  : one-cycle pulse when sw takes a new value
//   step : one-cycle pacing pulse for the light sequencer
// slave is the conditioner side, master is the side driving the switches.
interface tbird_switch_conditioner_if;
    logic       raw_left;
    logic       raw_right;
    logic       raw_haz;
    logic       raw_brk;
    logic [2:0] sw;
    logic       chg;
    logic       step;

    modport slave (
        input  raw_left,
        input  raw_right,
        input  raw_haz,
        input  raw_brk,
        output sw,
        output chg,
        output step
    );

    modport master (
        output raw_left,
        output raw_right,
        output raw_haz,
        output raw_brk,
        input  sw,
        input  chg,
        input  step
    );
endinterface

// File: rtl/tbird_switch_conditioner.sv
// Switch conditioner ahead of the Thunderbird tail-light sequencer.
// Each raw input is synchronised (2 flops), debounced (DB_CYCLES stable
// samples), encoded into the mode code {brake, left, right} and registered.
// A tick counter produces a STEP pulse every TICK_DIV cycles and restarts
// whenever the mode code changes.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : switch interface (slave modport): raw inputs in, sw/chg/step out
module tbird_switch_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int TICK_DIV  = 5,
    parameter int CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    tbird_switch_conditioner_if.slave     bus
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    // Bit order: 0 right, 1 left, 2 hazard, 3 brake.
    logic [3:0] raw;
    logic [3:0] level;

    assign raw = {bus.raw_brk, bus.raw_haz, bus.raw_left, bus.raw_right};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_input
            logic [1:0]       sync_reg;
            logic             level_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_reg <= 2'b00;
                end else begin
                    sync_reg <= {sync_reg[0], raw[gi]};
                end
            end

            // Any sample agreeing with the accepted level restarts the count,
            // so only an unbroken run of DB_CYCLES disagreeing samples flips it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    level_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else if (sync_reg[1] == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DB_LAST) begin
                    level_reg <= sync_reg[1];
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign level[gi] = level_reg;
        end
    endgenerate

    // Encode: hazard lights both sides; both stalks without hazard is a
    // stalk fault and lights neither side. Brake is independent.
    logic [2:0] enc;

    always_comb begin
        enc    = 3'b000;
        enc[0] = level[2] | (level[0] & ~level[1]);
        enc[1] = level[2] | (level[1] & ~level[0]);
        enc[2] = level[3];
    end

    logic [2:0]       sw_reg;
    logic             chg_reg;
    logic             step_reg;
    logic [CNT_W-1:0] tick_reg;
    logic             mode_change;

    assign mode_change = (enc != sw_reg);

    // A mode change restarts the cadence and suppresses a STEP due the same
    // cycle, so the first sequencer step lands a full period after the change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_reg   <= 3'b000;
            chg_reg  <= 1'b0;
            step_reg <= 1'b0;
            tick_reg <= '0;
        end else begin
            sw_reg  <= enc;
            chg_reg <= mode_change;
            if (mode_change) begin
                tick_reg <= '0;
                step_reg <= 1'b0;
            end else if (tick_reg == TICK_LAST) begin
                tick_reg <= '0;
                step_reg <= 1'b1;
            end else begin
                tick_reg <= tick_reg + 1'b1;
                step_reg <= 1'b0;
            end
        end
    end

    assign bus.sw   = sw_reg;
    assign bus.chg  = chg_reg;
    assign bus.step = step_reg;

endmodule

// File: tb/tb_tbird_switch_conditioner.sv
// Directed bench for tbird_switch_conditioner with default parameters
// (DB_CYCLES=4, TICK_DIV=5). Edges are numbered from 1 = first rising edge
// that samples the new stimulus; outputs are sampled 1 time unit after it.
module tb_tbird_switch_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    tbird_switch_conditioner_if bus ();

    tbird_switch_conditioner dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input logic haz, input logic brk, input logic left, input logic right);
        bus.raw_haz   = haz;
        bus.raw_brk   = brk;
        bus.raw_left  = left;
        bus.raw_right = right;
    endtask

    // Leaves the bench 1 unit after a rising edge with reset just released.
    task automatic do_reset();
        rst = 1'b1;
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        logic [4:0] exp;
        rst = 1'b1;
        set_raw(1'b1, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            got = {bus.sw, bus.chg, bus.step};
            vectors++;
            if (got !== 5'b00000) begin
                $display("FAIL reset_hold edge %0d: got sw/chg/step %b want 00000", k, got);
                miscompares++;
            end
        end
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            got = {bus.sw, bus.chg, bus.step};
            exp = {3'b000, 1'b0, (k == 5 || k == 10)};
            vectors++;
            if (got !== exp) begin
                $display("FAIL reset_release edge %0d: got sw/chg/step %b want %b", k, got, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_clean_press();
        logic [4:0] got;
        logic [4:0] exp;
        do_reset();
        bus.raw_right = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            got = {bus.sw, bus.chg, bus.step};
            exp = {(k >= 7) ? 3'b001 : 3'b000, (k == 7), (k == 5 || k == 12 || k == 17)};
            vectors++;
            if (got !== exp) begin
                $display("FAIL clean_press edge %0d: got sw/chg/step %b want %b", k, got, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] got;
        logic [3:0] exp;
        int         pulses;
        pulses = 0;
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            bus.raw_left = (k <= 2 || k == 5 || k == 6 || k >= 9);
            tick();
            if (bus.chg === 1'b1) pulses++;
            got = {bus.sw, bus.chg};
            exp = {(k >= 15) ? 3'b010 : 3'b000, (k == 15)};
            vectors++;
            if (got !== exp) begin
                $display("FAIL bounce edge %0d: got sw/chg %b want %b", k, got, exp);
                miscompares++;
            end
        end
        vectors++;
        if (pulses != 1) begin
            $display("FAIL bounce_chg_count: got %0d want 1", pulses);
            miscompares++;
        end
    endtask

    task automatic test_encoding();
        // {haz, brk, left, right, expected sw}
        logic [6:0] table_v [8];
        logic [6:0] entry;
        logic [3:0] got;
        logic [3:0] exp;
        table_v[0] = {4'b0011, 3'b000};
        table_v[1] = {4'b1011, 3'b011};
        table_v[2] = {4'b1100, 3'b111};
        table_v[3] = {4'b0101, 3'b101};
        table_v[4] = {4'b0110, 3'b110};
        table_v[5] = {4'b0001, 3'b001};
        table_v[6] = {4'b1000, 3'b011};
        table_v[7] = {4'b0100, 3'b100};
        for (int i = 0; i < 8; i++) begin
            entry = table_v[i];
            do_reset();
            set_raw(entry[6], entry[5], entry[4], entry[3]);
            for (int k = 1; k <= 6; k++) tick();
            vectors++;
            if (bus.sw !== 3'b000) begin
                $display("FAIL encode_early in %b edge 6: got sw %b want 000", entry[6:3], bus.sw);
                miscompares++;
            end
            tick();
            got = {bus.sw, bus.chg};
            exp = {entry[2:0], (entry[2:0] != 3'b000)};
            vectors++;
            if (got !== exp) begin
                $display("FAIL encode in %b edge 7: got sw/chg %b want %b", entry[6:3], got, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_tick_restart();
        logic [4:0] got;
        logic [4:0] exp;
        do_reset();
        for (int k = 1; k <= 21; k++) begin
            if (k == 4) bus.raw_brk = 1'b1;
            tick();
            got = {bus.sw, bus.chg, bus.step};
            exp = {(k >= 10) ? 3'b100 : 3'b000, (k == 10), (k == 5 || k == 15 || k == 20)};
            vectors++;
            if (got !== exp) begin
                $display("FAIL tick_restart edge %0d: got sw/chg/step %b want %b", k, got, exp);
                miscompares++;
            end
        end
        // Reset acts without waiting for a clock edge.
        rst = 1'b1;
        #1;
        got = {bus.sw, bus.chg, bus.step};
        vectors++;
        if (got !== 5'b00000) begin
            $display("FAIL async_reset: got sw/chg/step %b want 00000", got);
            miscompares++;
        end
        bus.raw_brk = 1'b0;
    endtask

    task automatic test_glitch_boundary();
        logic [3:0] got;
        logic [3:0] exp;
        // DB_CYCLES-1 samples high: never accepted.
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            bus.raw_right = (k <= 3);
            tick();
            got = {bus.sw, bus.chg};
            vectors++;
            if (got !== 4'b0000) begin
                $display("FAIL glitch3 edge %0d: got sw/chg %b want 0000", k, got);
                miscompares++;
            end
        end
        // Exactly DB_CYCLES samples high: accepted, then released again.
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            bus.raw_right = (k <= 4);
            tick();
            got = {bus.sw, bus.chg};
            exp = {(k >= 7 && k <= 10) ? 3'b001 : 3'b000, (k == 7 || k == 11)};
            vectors++;
            if (got !== exp) begin
                $display("FAIL glitch4 edge %0d: got sw/chg %b want %b", k, got, exp);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [3:0] got;
        logic [3:0] exp;
        do_reset();
        bus.raw_haz = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.sw !== 3'b000) begin
            $display("FAIL mid_reset_assert: got sw %b want 000", bus.sw);
            miscompares++;
        end
        tick();
        rst = 1'b0;
        vectors++;
        if (bus.sw !== 3'b000) begin
            $display("FAIL mid_reset_held: got sw %b want 000", bus.sw);
            miscompares++;
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            got = {bus.sw, bus.chg};
            exp = {(k >= 7) ? 3'b011 : 3'b000, (k == 7)};
            vectors++;
            if (got !== exp) begin
                $display("FAIL mid_reset_release edge %0d: got sw/chg %b want %b", k, got, exp);
                miscompares++;
            end
        end
    endtask

    initial begin
        set_raw(1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_clean_press();
        test_bounce();
        test_encoding();
        test_tick_restart();
        test_glitch_boundary();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
